count_seq_checker: RTL and testbench
====================================

# count_seq_checker

Sequence checker that sits directly downstream of the 3-bit up/down counter stages. Each enabled clock it samples the counter's bit vector and checks that the value is the expected successor of the previous sample: +1 when counting up, −1 when counting down, wrapping modulo 2^WIDTH. It declares lock after a run of correct transitions, and it flags and counts sequence breaks. Lab benches use it as a self-checking monitor in place of reading waveforms by eye.

## Interface
- WIDTH, 3, counter width in bits
- LOCK_N, 4, consecutive correct transitions required to assert `locked` (1..15)
- ERR_W, 8, width of the saturating error counter
- ALLOW_HOLD, 0, 1 = a sample equal to the previous sample is ignored (neither good nor bad)
- Clk  input  1  clock; all state updates on posedge
- rst  input  1  asynchronous, active-low reset
- en  input  1  sample enable; state and outputs frozen while 0
- dir  input  1  expected direction: 1 = up, 0 = down
- count  input  WIDTH  counter value under check
- locked  output  1  run of LOCK_N correct transitions observed, no break since
- err_pulse  output  1  one-cycle strobe on a sequence break while locked
- err_cnt  output  ERR_W  number of breaks while locked, saturating
- prev  output  WIDTH  last accepted sample

## Operation
- **Reset.** rst=0 forces, immediately and independent of Clk: state=IDLE, prev=0, good=0, locked=0, err_pulse=0, err_cnt=0.
- **Expected value.** exp = dir ? prev+1 : prev−1, truncated to WIDTH bits.
  - Up wrap: 2^WIDTH−1 → 0 is correct.
  - Down wrap: 0 → 2^WIDTH−1 is correct.
- **Internal good-run counter.** 4 bits, saturates at LOCK_N.
- **State IDLE** (no valid reference):
  - on en: prev←count, good←0, go TRACK.
  - Nothing is checked.
- **State TRACK:**
  - on en with count==exp: good←good+1, prev←count.
    - If good+1==LOCK_N: locked←1, go LOCKED.
  - on en with count==prev and ALLOW_HOLD=1: no change.
  - on en with any other value: good←0, prev←count, stay TRACK.
    - No err_pulse, no err_cnt change.
- **State LOCKED:**
  - on en with count==exp: prev←count.
  - on en with count==prev and ALLOW_HOLD=1: no change.
  - on en with any other value:
    - err_pulse←1, err_cnt←err_cnt+1 (held at 2^ERR_W−1 once reached).
    - locked←0, good←0, prev←count, go TRACK.
- **Direction change.** dir differing from its value at the previous enabled sample is a restart:
  - good←0, prev←count, go TRACK.
  - locked←0, no error.
  - The registered copy of dir resets to 1.
- **en=0.** Every register holds. err_pulse is cleared on the next edge regardless of en.
- **Simultaneous direction change and mismatch in LOCKED:** direction change wins; no error is counted.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- Check latency: a sample taken at edge k is reflected in locked, err_pulse, err_cnt and prev immediately after edge k.
- From IDLE, locked rises after edge LOCK_N+1 of a clean sequence: 1 capture plus LOCK_N good transitions.
- err_pulse is high for exactly one cycle per break. Back-to-back breaks cannot produce consecutive pulses, because the first break leaves LOCKED.
- Reset asserted mid-sequence clears everything asynchronously. After release, the first enabled edge is a capture only.
- The upstream counter must be clocked on the same Clk. A counter clocked on the opposite edge is valid if en gates one sample per count.

## Test plan
- **Up lock and wrap.** dir=1, count 2,3,4,5,6,7,0,1 on consecutive edges after reset → locked=1 after the 5th edge (value 6); 7→0 accepted; err_cnt=0.
- **Break while locked.** Locked on an up run, present 5 where 3 is expected → err_pulse=1 for one cycle, err_cnt=1, locked=0, prev=5. Then 6,7,0,1 → locked=1 again.
- **Down wrap and direction change.** dir=0, count 3,2,1,0,7 → locked=1 at 7. Then dir=1 with count 0 → locked=0, err_cnt unchanged, prev=0.
- **Enable and hold.** ALLOW_HOLD=1, locked. en=0 for 3 cycles with random count → outputs unchanged. Then en=1 with a repeated value → no error. Then the correct successor → still locked.
- **Saturation.** ERR_W=2, force 5 breaks, relocking between each → err_cnt sequence 1,2,3,3,3, with 5 err_pulse strobes.
- **Async reset mid-run.** Pull rst low between edges while locked with err_cnt=2 → locked, err_pulse, err_cnt, prev all 0 before the next edge. After release, the first edge captures and does not check.

Source files
------------

// File: rtl/count_seq_checker.sv
// Sequence monitor for an up/down counter: verifies each enabled sample is the
// modular successor of the previous one, declares lock and counts breaks.
module count_seq_checker #(
    parameter int unsigned WIDTH      = 3,
    parameter int unsigned LOCK_N     = 4,
    parameter int unsigned ERR_W      = 8,
    parameter bit          ALLOW_HOLD = 1'b0
) (
    input  logic             Clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic [WIDTH-1:0] count,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_cnt,
    output logic [WIDTH-1:0] prev
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_TRACK  = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    localparam logic [3:0]       LOCK_N_C = 4'(LOCK_N);
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   prev_q, prev_d;
    logic [3:0]         good_q, good_d;
    logic               locked_q, locked_d;
    logic               err_pulse_q, err_pulse_d;
    logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
    logic               dir_q, dir_d;

    logic [WIDTH-1:0]   exp_val;
    logic [3:0]         good_inc;
    logic               is_match;
    logic               is_hold;
    logic               dir_change;

    assign exp_val    = dir ? prev_q + WIDTH'(1) : prev_q - WIDTH'(1);
    assign is_match   = (count == exp_val);
    assign is_hold    = ALLOW_HOLD && (count == prev_q);
    assign dir_change = (dir != dir_q);
    // Good-run count saturates at LOCK_N so it stays pinned while locked.
    assign good_inc   = (good_q == LOCK_N_C) ? good_q : good_q + 4'd1;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge Clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            prev_q      <= '0;
            good_q      <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
            dir_q       <= 1'b1;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            good_q      <= good_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
            err_cnt_q   <= err_cnt_d;
            dir_q       <= dir_d;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        if (en) begin
            unique case (state_q)
                ST_IDLE:   state_d = ST_TRACK;
                ST_TRACK: begin
                    if (!dir_change && is_match && good_inc == LOCK_N_C)
                        state_d = ST_LOCKED;
                end
                ST_LOCKED: begin
                    if (dir_change || (!is_match && !is_hold))
                        state_d = ST_TRACK;
                end
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        prev_d      = prev_q;
        good_d      = good_q;
        locked_d    = locked_q;
        err_cnt_d   = err_cnt_q;
        dir_d       = dir_q;
        err_pulse_d = 1'b0;
        if (en) begin
            dir_d = dir;
            if (state_q == ST_IDLE || dir_change) begin
                // Capture or restart: new reference, nothing checked.
                prev_d   = count;
                good_d   = '0;
                locked_d = 1'b0;
            end else if (is_match) begin
                prev_d   = count;
                good_d   = good_inc;
                locked_d = (good_inc == LOCK_N_C);
            end else if (!is_hold) begin
                prev_d   = count;
                good_d   = '0;
                locked_d = 1'b0;
                if (state_q == ST_LOCKED) begin
                    err_pulse_d = 1'b1;
                    err_cnt_d   = (err_cnt_q == ERR_MAX) ? err_cnt_q
                                                         : err_cnt_q + ERR_W'(1);
                end
            end
        end
    end

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign err_cnt   = err_cnt_q;
    assign prev      = prev_q;

endmodule

// File: tb/tb_count_seq_checker.sv
// Bench for count_seq_checker: two instances (strict, and hold-tolerant with a
// 2-bit error counter) share stimulus; table vectors, directed corners, random.
module tb_count_seq_checker;

    localparam int W      = 3;
    localparam int MOD    = 1 << W;
    localparam int LOCK_N = 4;

    logic         Clk;
    logic         rst;
    logic         en;
    logic         dir;
    logic [W-1:0] count;

    logic         a_locked, a_err_pulse;
    logic [7:0]   a_err_cnt;
    logic [W-1:0] a_prev;
    logic         b_locked, b_err_pulse;
    logic [1:0]   b_err_cnt;
    logic [W-1:0] b_prev;

    count_seq_checker #(.WIDTH(W), .LOCK_N(LOCK_N), .ERR_W(8), .ALLOW_HOLD(1'b0)) dut_a (
        .Clk(Clk), .rst(rst), .en(en), .dir(dir), .count(count),
        .locked(a_locked), .err_pulse(a_err_pulse), .err_cnt(a_err_cnt), .prev(a_prev)
    );

    count_seq_checker #(.WIDTH(W), .LOCK_N(LOCK_N), .ERR_W(2), .ALLOW_HOLD(1'b1)) dut_b (
        .Clk(Clk), .rst(rst), .en(en), .dir(dir), .count(count),
        .locked(b_locked), .err_pulse(b_err_pulse), .err_cnt(b_err_cnt), .prev(b_prev)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Reference model: keeps the accepted reference value and the length of the
    // current run of correct transitions; lock is simply run >= LOCK_N.
    typedef struct {
        bit have;
        int ref_v;
        bit dir_ref;
        int run;
        int errs;
        bit pulse;
    } model_t;

    typedef struct {
        bit en;
        bit dir;
        int cnt;
        bit locked;
        bit pulse;
        int err;
        int prev;
    } vec_t;

    model_t ma, mb;
    int     n_cmp  = 0;
    int     n_fail = 0;

    function automatic model_t model_reset();
        model_t m;
        m.have = 0; m.ref_v = 0; m.dir_ref = 1; m.run = 0; m.errs = 0; m.pulse = 0;
        return m;
    endfunction

    function automatic model_t model_step(model_t m, bit e, bit d, int c, bit hold, int err_max);
        int expv;
        m.pulse = 0;
        if (!e) return m;
        if (!m.have || d != m.dir_ref) begin
            m.have = 1; m.dir_ref = d; m.ref_v = c; m.run = 0;
            return m;
        end
        expv = d ? (m.ref_v + 1) % MOD : (m.ref_v + MOD - 1) % MOD;
        if (c == expv) begin
            m.run++;
            m.ref_v = c;
        end else if (hold && c == m.ref_v) begin
            // tolerated repeat
        end else begin
            if (m.run >= LOCK_N) begin
                m.pulse = 1;
                if (m.errs < err_max) m.errs++;
            end
            m.run = 0;
            m.ref_v = c;
        end
        return m;
    endfunction

    task automatic check(input string name, input int actual, input int expected);
        n_cmp++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic check_a(input string tag, input bit l, input bit p, input int e, input int pv);
        check({tag, ".a.locked"},    int'(a_locked),    int'(l));
        check({tag, ".a.err_pulse"}, int'(a_err_pulse), int'(p));
        check({tag, ".a.err_cnt"},   int'(a_err_cnt),   e);
        check({tag, ".a.prev"},      int'(a_prev),      pv);
    endtask

    task automatic check_b(input string tag, input bit l, input bit p, input int e, input int pv);
        check({tag, ".b.locked"},    int'(b_locked),    int'(l));
        check({tag, ".b.err_pulse"}, int'(b_err_pulse), int'(p));
        check({tag, ".b.err_cnt"},   int'(b_err_cnt),   e);
        check({tag, ".b.prev"},      int'(b_prev),      pv);
    endtask

    // Drive inputs mid-cycle, take one edge, then sample 1 time unit later.
    task automatic tick(input bit e, input bit d, input int c);
        en    = e;
        dir   = d;
        count = W'(c);
        @(posedge Clk);
        #1;
        ma = model_step(ma, e, d, c, 1'b0, 255);
        mb = model_step(mb, e, d, c, 1'b1, 3);
    endtask

    task automatic do_reset();
        en  = 1'b0;
        rst = 1'b0;
        #2;
        rst = 1'b1;
        ma = model_reset();
        mb = model_reset();
    endtask

    vec_t tbl[23];

    initial begin
        int p;
        int bad;
        int pulses;
        bit rdir;
        int c;

        tbl[0]  = '{1, 1, 2, 0, 0, 0, 2};
        tbl[1]  = '{1, 1, 3, 0, 0, 0, 3};
        tbl[2]  = '{1, 1, 4, 0, 0, 0, 4};
        tbl[3]  = '{1, 1, 5, 0, 0, 0, 5};
        tbl[4]  = '{1, 1, 6, 1, 0, 0, 6};
        tbl[5]  = '{1, 1, 7, 1, 0, 0, 7};
        tbl[6]  = '{1, 1, 0, 1, 0, 0, 0};
        tbl[7]  = '{1, 1, 1, 1, 0, 0, 1};
        tbl[8]  = '{1, 1, 2, 1, 0, 0, 2};
        tbl[9]  = '{1, 1, 5, 0, 1, 1, 5};
        tbl[10] = '{0, 1, 6, 0, 0, 1, 5};
        tbl[11] = '{1, 1, 6, 0, 0, 1, 6};
        tbl[12] = '{1, 1, 7, 0, 0, 1, 7};
        tbl[13] = '{1, 1, 0, 0, 0, 1, 0};
        tbl[14] = '{1, 1, 1, 1, 0, 1, 1};
        tbl[15] = '{1, 0, 3, 0, 0, 1, 3};
        tbl[16] = '{1, 0, 2, 0, 0, 1, 2};
        tbl[17] = '{1, 0, 1, 0, 0, 1, 1};
        tbl[18] = '{1, 0, 0, 0, 0, 1, 0};
        tbl[19] = '{1, 0, 7, 1, 0, 1, 7};
        tbl[20] = '{1, 1, 0, 0, 0, 1, 0};
        tbl[21] = '{0, 0, 5, 0, 0, 1, 0};
        tbl[22] = '{1, 1, 1, 0, 0, 1, 1};

        rst   = 1'b0;
        en    = 1'b0;
        dir   = 1'b1;
        count = '0;
        ma = model_reset();
        mb = model_reset();
        @(posedge Clk);
        #1;
        check_a("reset", 0, 0, 0, 0);
        check_b("reset", 0, 0, 0, 0);
        rst = 1'b1;

        // Up lock and wrap, break while locked, down wrap, direction change.
        for (int i = 0; i < 23; i++) begin
            tick(tbl[i].en, tbl[i].dir, tbl[i].cnt);
            check_a($sformatf("vec%0d", i), tbl[i].locked, tbl[i].pulse, tbl[i].err, tbl[i].prev);
        end

        // Enable gating and tolerated repeat (instance b), strict repeat (instance a).
        do_reset();
        for (int i = 0; i <= 4; i++) tick(1, 1, i);
        check_b("hold.locked", 1, 0, 0, 4);
        for (int i = 0; i < 3; i++) begin
            tick(0, 1'($urandom_range(0, 1)), int'($urandom_range(0, MOD - 1)));
            check_b($sformatf("hold.en0_%0d", i), 1, 0, 0, 4);
            check_a($sformatf("hold.en0_%0d", i), 1, 0, 0, 4);
        end
        tick(1, 1, 4);
        check_b("hold.repeat", 1, 0, 0, 4);
        check_a("hold.repeat", 0, 1, 1, 4);
        tick(1, 1, 5);
        check_b("hold.succ", 1, 0, 0, 5);

        // Saturating error counter on the 2-bit instance, relocking between breaks.
        p = 5;
        pulses = 0;
        for (int k = 0; k < 5; k++) begin
            bad = (p + 3) % MOD;
            tick(1, 1, bad);
            if (b_err_pulse) pulses++;
            check_b($sformatf("sat%0d", k), 0, 1, (k + 1 < 3) ? k + 1 : 3, bad);
            p = bad;
            for (int j = 1; j <= LOCK_N; j++) begin
                p = (p + 1) % MOD;
                tick(1, 1, p);
                if (b_err_pulse) pulses++;
            end
            check(($sformatf("sat%0d.relock", k)), int'(b_locked), 1);
        end
        check("sat.pulses", pulses, 5);

        // Async reset while locked with two errors recorded.
        do_reset();
        p = 0;
        tick(1, 1, p);
        for (int k = 0; k < 3; k++) begin
            for (int j = 1; j <= LOCK_N; j++) begin
                p = (p + 1) % MOD;
                tick(1, 1, p);
            end
            if (k < 2) begin
                p = (p + 3) % MOD;
                tick(1, 1, p);
            end
        end
        check_a("arst.pre", 1, 0, 2, p);
        rst = 1'b0;
        #1;
        check_a("arst.during", 0, 0, 0, 0);
        check_b("arst.during", 0, 0, 0, 0);
        #1;
        rst = 1'b1;
        ma = model_reset();
        mb = model_reset();
        tick(1, 1, 5);
        check_a("arst.capture", 0, 0, 0, 5);
        tick(1, 1, 3);
        check_a("arst.track", 0, 0, 0, 3);

        // Random stimulus against the reference model on both instances.
        do_reset();
        rdir = 1'b1;
        c = 0;
        for (int i = 0; i < 3000; i++) begin
            int r;
            if (i == 1500) do_reset();
            if ($urandom_range(0, 29) == 0) rdir = ~rdir;
            r = int'($urandom_range(0, 9));
            if (r < 7)       c = rdir ? (c + 1) % MOD : (c + MOD - 1) % MOD;
            else if (r == 8) c = int'($urandom_range(0, MOD - 1));
            tick(($urandom_range(0, 9) != 0), rdir, c);
            check_a($sformatf("rnd%0d", i), ma.run >= LOCK_N, ma.pulse, ma.errs, ma.ref_v);
            check_b($sformatf("rnd%0d", i), mb.run >= LOCK_N, mb.pulse, mb.errs, mb.ref_v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
